// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin share of one montgomery_reduce (req0/req1 in, mont_* to reducer, res0/res1 out, idle)
module mont_arbiter #(
  parameter int MONT_LAT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               req0_valid,
  input  logic signed [31:0] req0_a,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic signed [31:0] req1_a,
  output logic               req1_ready,
  output logic               res0_valid,
  output logic signed [15:0] res0_t,
  output logic               res1_valid,
  output logic signed [15:0] res1_t,
  output logic               mont_set,
  output logic signed [31:0] mont_a,
  input  logic signed [15:0] mont_t,
  output logic               idle
);
  logic              rr;
  logic              acc;
  logic [MONT_LAT:0] trk_v;
  logic [MONT_LAT:0] trk_id;
  always_comb begin
    req0_ready = ~reset & en & req0_valid & (~req1_valid | ~rr);
    req1_ready = ~reset & en & req1_valid & (~req0_valid | rr);
    acc = req0_ready | req1_ready;
    idle = ~|trk_v & ~res0_valid & ~res1_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= 1'b0;
      trk_v <= '0;
      trk_id <= '0;
      mont_a <= '0;
      mont_set <= 1'b0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_t <= '0;
      res1_t <= '0;
    end else begin
      mont_set <= 1'b1;
      if (acc) begin
        rr <= req0_ready;
        mont_a <= req0_ready ? req0_a : req1_a;
      end
      trk_v <= (trk_v << 1) | (MONT_LAT+1)'(acc);
      trk_id <= (trk_id << 1) | (MONT_LAT+1)'(req1_ready);
      res0_valid <= trk_v[MONT_LAT] & ~trk_id[MONT_LAT];
      res1_valid <= trk_v[MONT_LAT] & trk_id[MONT_LAT];
      if (trk_v[MONT_LAT] & ~trk_id[MONT_LAT]) res0_t <= mont_t;
      if (trk_v[MONT_LAT] & trk_id[MONT_LAT]) res1_t <= mont_t;
    end
  end
endmodule

// File: tb/tb_mont_arbiter.sv
// tb_mont_arbiter: directed checks of mont_arbiter with combinational and 3-cycle reducer models
module tb_mont_arbiter;
  logic clk = 1'b0;
  logic rst, en;
  logic v0, v1, ready0, ready1, res0v, res1v, mset, idle;
  logic signed [31:0] a0, a1, ma;
  logic signed [15:0] res0t, res1t, mt;
  logic b_v0, b_v1, b_ready0, b_ready1, b_res0v, b_res1v, b_mset, b_idle;
  logic signed [31:0] b_a0, b_a1, b_ma;
  logic signed [15:0] b_res0t, b_res1t, b_mt;
  logic signed [31:0] dl [3];
  int nchk = 0;
  int nfail = 0;
  int ops [10];
  always #5 clk = ~clk;
  function automatic logic signed [15:0] red(input logic signed [31:0] a);
    logic signed [15:0] u;
    longint r;
    u = 16'(a[15:0] * 16'd62209);
    r = (longint'(a) - longint'(u) * 3329) >>> 16;
    if (r >= 3329) r -= 3329;
    if (r <= -3329) r += 3329;
    return 16'(r);
  endfunction
  assign mt = red(ma);
  always @(posedge clk) begin
    dl[0] <= b_ma;
    dl[1] <= dl[0];
    dl[2] <= dl[1];
  end
  assign b_mt = red(dl[2]);
  mont_arbiter #(.MONT_LAT(0)) dut0 (
    .clk(clk), .reset(rst), .en(en),
    .req0_valid(v0), .req0_a(a0), .req0_ready(ready0),
    .req1_valid(v1), .req1_a(a1), .req1_ready(ready1),
    .res0_valid(res0v), .res0_t(res0t), .res1_valid(res1v), .res1_t(res1t),
    .mont_set(mset), .mont_a(ma), .mont_t(mt), .idle(idle)
  );
  mont_arbiter #(.MONT_LAT(3)) dut3 (
    .clk(clk), .reset(rst), .en(en),
    .req0_valid(b_v0), .req0_a(b_a0), .req0_ready(b_ready0),
    .req1_valid(b_v1), .req1_a(b_a1), .req1_ready(b_ready1),
    .res0_valid(b_res0v), .res0_t(b_res0t), .res1_valid(b_res1v), .res1_t(b_res1t),
    .mont_set(b_mset), .mont_a(b_ma), .mont_t(b_mt), .idle(b_idle)
  );
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    en = 1'b1;
    {v0, v1, b_v0, b_v1} = '0;
    {a0, a1, b_a0, b_a1} = '0;
    @(posedge clk); #1;
    chk("rst_ready0", ready0, 0); chk("rst_ready1", ready1, 0);
    chk("rst_res0v", res0v, 0); chk("rst_res1v", res1v, 0);
    chk("rst_res0t", res0t, 0); chk("rst_res1t", res1t, 0);
    chk("rst_mont_a", ma, 0); chk("rst_mset", mset, 0); chk("rst_idle", idle, 1);
    chk("rst_b_res0v", b_res0v, 0); chk("rst_b_res1v", b_res1v, 0);
    chk("rst_b_res1t", b_res1t, 0); chk("rst_b_mont_a", b_ma, 0);
    chk("rst_b_mset", b_mset, 0); chk("rst_b_idle", b_idle, 1);
    rst = 1'b0;
  endtask
  task automatic seq(input int n, input logic [15:0] en_m, input int g [12], input int r [12]);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      en = en_m[i];
      v0 = (i < 8);
      v1 = (i < 8);
      a0 = 65536;
      a1 = -65536;
      #1;
      chk("grant0", ready0, g[i] == 0);
      chk("grant1", ready1, g[i] == 1);
      chk("res0v", res0v, r[i] == 0);
      chk("res1v", res1v, r[i] == 1);
      if (r[i] == 0) chk("res0t", res0t, 1);
      if (r[i] == 1) chk("res1t", res1t, -1);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    en = 1'b1;
  endtask
  initial begin
    do_reset();
    // single operand, combinational reducer
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 65536;
    #1;
    chk("t1_mset", mset, 1);
    chk("t1_ready0", ready0, 1); chk("t1_ready1", ready1, 0);
    @(posedge clk); #1;
    v0 = 1'b0;
    #1;
    chk("t1_mont_a", ma, 65536); chk("t1_early", res0v, 0); chk("t1_busy", idle, 0);
    @(posedge clk); #1;
    chk("t1_res0v", res0v, 1); chk("t1_res0t", res0t, 1); chk("t1_res1v", res1v, 0);
    @(posedge clk); #1;
    chk("t1_pulse", res0v, 0); chk("t1_idle", idle, 1); chk("t1_hold", res0t, 1);
    // contention: strict alternation from port 0
    do_reset();
    seq(11, 16'hFFFF, '{0, 1, 0, 1, 0, 1, 0, 1, 2, 2, 2, 2}, '{2, 2, 0, 1, 0, 1, 0, 1, 0, 1, 2, 2});
    @(posedge clk); #1;
    chk("t2_idle", idle, 1);
    // en low in cycles 3..5 of contention
    do_reset();
    seq(11, 16'hFFC7, '{0, 1, 0, 2, 2, 2, 1, 0, 2, 2, 2, 2}, '{2, 2, 0, 1, 0, 2, 2, 2, 1, 0, 2, 2});
    // q*R on port 0 then 0 on port 1
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 218169344;
    #1;
    chk("t6_ready0", ready0, 1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b1; a1 = 0;
    #1;
    chk("t6_ready1", ready1, 1);
    @(posedge clk); #1;
    v1 = 1'b0;
    #1;
    chk("t6_res0v", res0v, 1); chk("t6_res0t", res0t, 0); chk("t6_res1v_lo", res1v, 0);
    @(posedge clk); #1;
    chk("t6_res1v", res1v, 1); chk("t6_res1t", res1t, 0); chk("t6_res0v_lo", res0v, 0);
    // MONT_LAT=3 stream of 10 random operands on port 1
    do_reset();
    for (int i = 0; i < 10; i++) ops[i] = int'($urandom_range(200000000)) - 100000000;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      b_v1 = (i < 10);
      b_a1 = (i < 10) ? ops[i] : 0;
      #1;
      if (i < 10) chk("l3_ready1", b_ready1, 1);
      chk("l3_res1v", b_res1v, i >= 5 && i < 15);
      chk("l3_res0v", b_res0v, 0);
      if (i >= 5 && i < 15) begin
        chk("l3_res1t", b_res1t, red(ops[i-5]));
        chk("l3_cong", (longint'(b_res1t) * 2285 - longint'(ops[i-5])) % 3329, 0);
      end
    end
    // reset with two operands in flight in the 3-cycle pipeline
    @(posedge clk); #1;
    b_v1 = 1'b1; b_a1 = 65536;
    @(posedge clk); #1;
    b_a1 = -65536;
    @(posedge clk); #1;
    chk("rm_busy", b_idle, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rm_res0v", b_res0v, 0);
      chk("rm_res1v", b_res1v, 0);
    end
    chk("rm_idle", b_idle, 1);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
